// File: rtl/fsb_term.sv
// 68000 bus-cycle terminator: merges ready/error sources into DTACK/VPA/BERR,
// enforces minimum wait states and converts hung cycles into watchdog bus errors.

module fsb_sticky (
  input  logic FCLK,
  input  logic Reset,
  input  logic clr,
  input  logic d,
  output logic q
);
  always_ff @(posedge FCLK) begin
    if (Reset || clr) q <= 1'b0;
    else if (d)       q <= 1'b1;
  end
endmodule

module fsb_term #(
  parameter int NREADY  = 4,
  parameter int NBERR   = 2,
  parameter int WAITMIN = 0,
  parameter int TW      = 8,
  parameter int TIMEOUT = 200
) (
  input  logic              FCLK,
  input  logic              Reset,
  input  logic [1:0]        SS,
  input  logic              nAS,
  input  logic [NREADY-1:0] Ready,
  input  logic [NREADY-1:0] ReadyMask,
  input  logic              Disable,
  input  logic [NBERR-1:0]  BERRin,
  input  logic              IACS,
  input  logic              TimeoutEn,
  output logic              BACT,
  output logic              nDTACK,
  output logic              nVPA,
  output logic              nBERR,
  output logic              TimedOut,
  output logic [7:0]        ErrCount
);
  typedef enum logic [1:0] {IDLE, WAIT, TERM, FAULT} state_t;

  localparam logic [TW-1:0] CMAX  = '1;
  localparam logic [TW-1:0] TO_M1 = TW'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [TW-1:0]     cnt, cnt_nx;
  logic              vpar, vpa_nx, dtack_nx, to_nx;
  logic [7:0]        errc_nx;
  logic [NREADY-1:0] ready_r;
  logic [NBERR-1:0]  berr_r;
  logic              ready_all, berr_any, wait_ok;

  always_ff @(posedge FCLK) begin
    if (Reset)                   BACT <= 1'b0;
    else if (SS == 2'd1 && !nAS) BACT <= 1'b1;
    else if (SS == 2'd3 && nAS)  BACT <= 1'b0;
  end

  // Sources may pulse early in the cycle; remember them until the cycle ends.
  for (genvar i = 0; i < NREADY; i++) begin : g_rdy
    fsb_sticky u_rdy (.FCLK(FCLK), .Reset(Reset), .clr(~BACT), .d(Ready[i]), .q(ready_r[i]));
  end
  for (genvar j = 0; j < NBERR; j++) begin : g_berr
    fsb_sticky u_berr (.FCLK(FCLK), .Reset(Reset), .clr(~BACT), .d(BERRin[j]), .q(berr_r[j]));
  end

  if (WAITMIN == 0) begin : g_nomin
    assign wait_ok = 1'b1;
  end else begin : g_min
    assign wait_ok = (cnt >= TW'(WAITMIN));
  end

  assign ready_all = ~Disable & (&(Ready | ready_r | ~ReadyMask));
  assign berr_any  = (|(BERRin | berr_r)) | TimedOut;
  assign nVPA      = ~(~nAS & vpar);
  assign nBERR     = ~(~nAS & berr_any);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dtack_nx = nDTACK;
    vpa_nx   = vpar;
    to_nx    = TimedOut;
    errc_nx  = ErrCount;
    if (!BACT) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      dtack_nx = 1'b1;
      vpa_nx   = 1'b0;
      to_nx    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nx   = '0;
          state_nx = WAIT;
        end
        WAIT: begin
          if (cnt != CMAX) cnt_nx = cnt + 1'b1;
          // Errors win over ready on the same edge so no ack ever escapes.
          if (berr_any) begin
            state_nx = FAULT;
          end else if (TimeoutEn && cnt == TO_M1) begin
            state_nx = FAULT;
            to_nx    = 1'b1;
            if (ErrCount != 8'hFF) errc_nx = ErrCount + 8'd1;
          end else if (ready_all && wait_ok) begin
            state_nx = TERM;
            dtack_nx = IACS;
            vpa_nx   = IACS;
          end
        end
        TERM: state_nx = TERM;
        FAULT: begin
          dtack_nx = 1'b1;
          vpa_nx   = 1'b0;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge FCLK) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      nDTACK   <= 1'b1;
      vpar     <= 1'b0;
      TimedOut <= 1'b0;
      ErrCount <= 8'd0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      nDTACK   <= dtack_nx;
      vpar     <= vpa_nx;
      TimedOut <= to_nx;
      ErrCount <= errc_nx;
    end
  end
endmodule

// File: tb/tb_fsb_term.sv
// Scoreboard bench for fsb_term: a per-cycle outcome model feeds a queue that an
// independent monitor drains each time the DUT ends a bus cycle.

module tb_fsb_term;
  localparam int NREADY = 4, NBERR = 2, WAITMIN = 2, TW = 8, TIMEOUT = 20;

  logic       FCLK = 1'b0, Reset = 1'b1;
  logic [1:0] SS = 2'd0;
  logic       nAS = 1'b1;
  logic [3:0] Ready = '0, ReadyMask = '1;
  logic       Disable = 1'b0;
  logic [1:0] BERRin = '0;
  logic       IACS = 1'b0, TimeoutEn = 1'b0;
  logic       BACT, nDTACK, nVPA, nBERR, TimedOut;
  logic [7:0] ErrCount;

  fsb_term #(.NREADY(NREADY), .NBERR(NBERR), .WAITMIN(WAITMIN), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
    .FCLK(FCLK), .Reset(Reset), .SS(SS), .nAS(nAS), .Ready(Ready), .ReadyMask(ReadyMask),
    .Disable(Disable), .BERRin(BERRin), .IACS(IACS), .TimeoutEn(TimeoutEn),
    .BACT(BACT), .nDTACK(nDTACK), .nVPA(nVPA), .nBERR(nBERR), .TimedOut(TimedOut),
    .ErrCount(ErrCount)
  );

  always #5 FCLK = ~FCLK;

  // kind: 0 none, 1 DTACK, 2 VPA, 3 source BERR, 4 watchdog, 7 inconsistent
  typedef struct { int kind; int w; int errc; } exp_t;
  exp_t expq[$];
  int   checks = 0, errors = 0, errc_exp = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One bus cycle; the outcome is predicted from the WAIT-edge rules as inputs are chosen.
  task automatic run_cycle(input int mode);
    logic [3:0] mask, racc;
    logic [1:0] bacc;
    logic       iacs, done, rall;
    int         cap, post, kind, we;
    exp_t       ex;
    mask = 4'hF; iacs = 1'b0; cap = 30;
    case (mode)
      0: begin mask = 4'($urandom); iacs = 1'($urandom); cap = 40; end
      1: cap = TIMEOUT + 5;
      2: cap = 310;
      3: mask = 4'b0011;
      5: iacs = 1'b1;
      default: ;
    endcase
    ReadyMask = mask; IACS = iacs;
    Ready = '0; BERRin = '0; Disable = 1'b0; TimeoutEn = 1'b1;
    nAS = 1'b0; SS = 2'd1;
    @(posedge FCLK); #1;
    SS = 2'd0;
    racc = '0; bacc = '0; done = 1'b0; post = 0; kind = 0; we = 0;
    for (int e = 0; e <= cap; e++) begin
      Ready = '0; BERRin = '0; Disable = 1'b0; TimeoutEn = 1'b1;
      if (!done) begin
        case (mode)
          0: begin
            Ready     = 4'($urandom & $urandom);
            BERRin    = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            Disable   = ($urandom_range(0, 3) == 0);
            TimeoutEn = ($urandom_range(0, 7) != 0);
          end
          2: begin Ready = '1; Disable = (e < 300); TimeoutEn = 1'b0; end
          3: Ready = {2'($urandom), e == 4, e == 2};
          4: begin Ready = '1; BERRin = (e == 3) ? 2'b10 : 2'b00; end
          5: Ready = '1;
          default: ;
        endcase
        if (e >= 1) begin
          rall = !Disable && ((Ready | racc | ~mask) == 4'hF);
          if (|(BERRin | bacc)) begin
            kind = 3; done = 1'b1;
          end else if (TimeoutEn && e == TIMEOUT) begin
            kind = 4; we = e; done = 1'b1;
            if (errc_exp < 255) errc_exp++;
          end else if (rall && (e - 1) >= WAITMIN) begin
            kind = iacs ? 2 : 1; we = e; done = 1'b1;
          end
        end
      end
      racc |= Ready; bacc |= BERRin;
      @(posedge FCLK); #1;
      if (done) post++;
      if (post >= 2) break;
    end
    ex.kind = kind; ex.w = we; ex.errc = errc_exp;
    expq.push_back(ex);
    Ready = '0; BERRin = '0; nAS = 1'b1; SS = 2'd3;
    @(posedge FCLK); #1;
    SS = 2'd0;
    repeat (2) @(posedge FCLK);
    #1;
  endtask

  // Monitor: reconstructs each cycle's outcome purely from the DUT pins.
  initial begin
    bit   prevb = 0, dt = 0, vp = 0, nb = 0, to = 0;
    int   n = 0, dtw = 0, vpw = 0, tow = 0, idle = 0, k, w;
    exp_t ex;
    forever begin
      @(negedge FCLK);
      if (!mon_en) begin
        idle = 0;
      end else if (BACT) begin
        if (!prevb) begin n = 0; dt = 0; vp = 0; nb = 0; to = 0; end
        else n++;
        if (!nDTACK && !dt)  begin dt = 1; dtw = n - 1; end
        if (!nVPA && !vp)    begin vp = 1; vpw = n - 1; end
        if (TimedOut && !to) begin to = 1; tow = n - 1; end
        if (!nBERR) nb = 1;
      end else if (prevb) begin
        k = 7; w = 0;
        if (to)                    begin if (!dt && !vp && nb) begin k = 4; w = tow; end end
        else if (dt && !vp && !nb) begin k = 1; w = dtw; end
        else if (vp && !dt && !nb) begin k = 2; w = vpw; end
        else if (nb && !dt && !vp) k = 3;
        else if (!dt && !vp)       k = 0;
        if (expq.size() == 0) chk("unexpected bus cycle", 1, 0);
        else begin
          ex = expq.pop_front();
          chk("termination kind", k, ex.kind);
          chk("termination wait edge", w, ex.w);
          chk("ErrCount", int'(ErrCount), ex.errc);
        end
        idle = 1;
      end else if (idle == 1) begin
        chk("idle {nDTACK,nVPA,nBERR,TimedOut}", int'({nDTACK, nVPA, nBERR, TimedOut}), 4'b1110);
        idle = 0;
      end
      prevb = BACT;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int waited;
    repeat (2) @(posedge FCLK);
    #1;
    chk("reset BACT", BACT, 0);
    chk("reset nDTACK", nDTACK, 1);
    chk("reset nVPA", nVPA, 1);
    chk("reset nBERR", nBERR, 1);
    chk("reset TimedOut", TimedOut, 0);
    chk("reset ErrCount", int'(ErrCount), 0);
    Reset = 1'b0;
    @(posedge FCLK); #1;
    mon_en = 1'b1;

    run_cycle(3);               // masked sources pulsing on different edges
    run_cycle(5);               // interrupt ack -> VPA after WAITMIN
    run_cycle(4);               // BERR and ready on the same edge
    run_cycle(2);               // Disable held far past counter saturation
    for (int i = 0; i < 150; i++) run_cycle(0);
    for (int i = 0; i < 260; i++) run_cycle(1);   // ErrCount saturation

    // Reset while terminated with DTACK low
    mon_en = 1'b0;
    ReadyMask = '1; IACS = 1'b0; Ready = '1; TimeoutEn = 1'b0;
    nAS = 1'b0; SS = 2'd1;
    @(posedge FCLK); #1;
    SS = 2'd0;
    waited = 0;
    while (nDTACK && waited < 20) begin @(posedge FCLK); #1; waited++; end
    chk("DTACK before reset", nDTACK, 0);
    Reset = 1'b1;
    @(posedge FCLK); #1;
    chk("mid-cycle reset nDTACK", nDTACK, 1);
    chk("mid-cycle reset BACT", BACT, 0);
    chk("mid-cycle reset ErrCount", int'(ErrCount), 0);
    chk("mid-cycle reset TimedOut", TimedOut, 0);
    Reset = 1'b0; nAS = 1'b1; Ready = '0;
    repeat (2) @(posedge FCLK);
    #1;
    errc_exp = 0;
    mon_en = 1'b1;
    run_cycle(3);
    run_cycle(1);

    repeat (3) @(posedge FCLK);
    #1;
    chk("pending expectations", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
